// File: rtl/stat_counter_ctrl.sv
// stat_counter_ctrl: run/halt sequencer for the MIPS core plus a bank of four
// wrapping statistics counters (cycles, jumps, taken branches, halts) that the
// board display reads through a sel-addressed mux.
module stat_counter_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             halt,
    input  logic             go,
    input  logic             ev_jump,
    input  logic             ev_branch,
    input  logic             cnt_clr,
    input  logic [1:0]       sel,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] cnt_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_STEP = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cycle_cnt;
    logic [WIDTH-1:0] r_jump_cnt;
    logic [WIDTH-1:0] r_branch_cnt;
    logic [WIDTH-1:0] r_halt_cnt;

    logic             w_active;
    logic             w_halt_evt;

    // The core executes (and events count) only in RUN and STEP.
    assign w_active   = (r_state == ST_RUN) || (r_state == ST_STEP);
    // The halting instruction itself is counted on the RUN->HALT edge.
    assign w_halt_evt = (r_state == ST_RUN) && halt;

    assign cpu_en = w_active;
    assign state  = r_state;

    // Run/halt sequencer; STEP lasts one cycle and ignores halt so the PC
    // moves past the syscall that is still being decoded.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start) r_state <= ST_RUN;
                ST_RUN:  if (halt)  r_state <= ST_HALT;
                ST_HALT: if (go)    r_state <= ST_STEP;
                ST_STEP: r_state <= ST_RUN;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Event counters; soft clear beats any same-cycle increment, all wrap.
    always_ff @(posedge clk) begin
        if (clr || cnt_clr) begin
            r_cycle_cnt  <= '0;
            r_jump_cnt   <= '0;
            r_branch_cnt <= '0;
            r_halt_cnt   <= '0;
        end else begin
            if (w_active) begin
                r_cycle_cnt <= r_cycle_cnt + WIDTH'(1);
            end
            if (w_active && ev_jump) begin
                r_jump_cnt <= r_jump_cnt + WIDTH'(1);
            end
            if (w_active && ev_branch) begin
                r_branch_cnt <= r_branch_cnt + WIDTH'(1);
            end
            if (w_halt_evt) begin
                r_halt_cnt <= r_halt_cnt + WIDTH'(1);
            end
        end
    end

    // Zero-latency display mux over the registered counts.
    always_comb begin
        cnt_out = '0;
        case (sel)
            2'd0:    cnt_out = r_cycle_cnt;
            2'd1:    cnt_out = r_jump_cnt;
            2'd2:    cnt_out = r_branch_cnt;
            2'd3:    cnt_out = r_halt_cnt;
            default: cnt_out = '0;
        endcase
    end

endmodule

// File: tb/tb_stat_counter_ctrl.sv
// Bench for stat_counter_ctrl: a behavioural model predicts state/cpu_en/count
// each cycle into a scoreboard queue; a 32-bit and a 4-bit instance share the
// same stimulus so counter wrap is observable on the narrow one.
module tb_stat_counter_ctrl;

    typedef struct {
        logic [1:0]  st;
        logic        en;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        go = 1'b0;
    logic        ev_jump = 1'b0;
    logic        ev_branch = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] cnt_out;
    logic        cpu_en4;
    logic [1:0]  state4;
    logic [3:0]  cnt_out4;

    logic [1:0]  m_state;
    logic [31:0] m_cnt [4];
    exp_t        sb [$];

    int          n_checks = 0;
    int          n_errors = 0;

    always #10 clk = ~clk;

    stat_counter_ctrl #(.WIDTH(32)) u_dut (
        .clk(clk), .clr(clr), .start(start), .halt(halt), .go(go),
        .ev_jump(ev_jump), .ev_branch(ev_branch), .cnt_clr(cnt_clr), .sel(sel),
        .cpu_en(cpu_en), .state(state), .cnt_out(cnt_out)
    );

    stat_counter_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .clr(clr), .start(start), .halt(halt), .go(go),
        .ev_jump(ev_jump), .ev_branch(ev_branch), .cnt_clr(cnt_clr), .sel(sel),
        .cpu_en(cpu_en4), .state(state4), .cnt_out(cnt_out4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference behaviour for one clock edge, using the inputs now driven.
    task automatic model_step();
        logic act;
        act = (m_state == 2'b01) || (m_state == 2'b11);
        if (clr) begin
            m_state = 2'b00;
            for (int i = 0; i < 4; i++) m_cnt[i] = 32'd0;
        end else begin
            if (cnt_clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 32'd0;
            end else begin
                if (act)                       m_cnt[0] = m_cnt[0] + 32'd1;
                if (act && ev_jump)            m_cnt[1] = m_cnt[1] + 32'd1;
                if (act && ev_branch)          m_cnt[2] = m_cnt[2] + 32'd1;
                if (m_state == 2'b01 && halt)  m_cnt[3] = m_cnt[3] + 32'd1;
            end
            case (m_state)
                2'b00:   if (start) m_state = 2'b01;
                2'b01:   if (halt)  m_state = 2'b10;
                2'b10:   if (go)    m_state = 2'b11;
                default: m_state = 2'b01;
            endcase
        end
    endtask

    task automatic sb_push();
        exp_t e;
        e.st  = m_state;
        e.en  = (m_state == 2'b01) || (m_state == 2'b11);
        e.cnt = m_cnt[sel];
        sb.push_back(e);
    endtask

    task automatic sb_compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("state",    64'(state),    64'(e.st));
            check("cpu_en",   64'(cpu_en),   64'(e.en));
            check("cnt_out",  64'(cnt_out),  64'(e.cnt));
            check("state4",   64'(state4),   64'(e.st));
            check("cnt_out4", 64'(cnt_out4), 64'(e.cnt[3:0]));
        end
    endtask

    // One clock: drive at negedge, predict, compare just after posedge.
    task automatic cyc(input logic c, input logic s, input logic h, input logic g,
                       input logic j, input logic b, input logic cc);
        @(negedge clk);
        clr = c; start = s; halt = h; go = g;
        ev_jump = j; ev_branch = b; cnt_clr = cc;
        model_step();
        sb_push();
        @(posedge clk);
        #1;
        sb_compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboarded read of all four counters through the mux.
    task automatic read_all();
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            sb_push();
            #1;
            sb_compare();
        end
        sel = 2'd0;
    endtask

    // Direct read against a hand-derived constant.
    task automatic check_sel(input string tag, input logic [1:0] s, input logic [31:0] v);
        sel = s;
        #1;
        check(tag, 64'(cnt_out), 64'(v));
        sel = 2'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_state = 2'b00;
        for (int i = 0; i < 4; i++) m_cnt[i] = 32'd0;

        // Reset and idle
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(5);
        check("rst_state", 64'(state), 64'd0);
        check("rst_cpu_en", 64'(cpu_en), 64'd0);
        read_all();

        // Start, then 10 running cycles with events
        cyc(0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            cyc(0, 0, 0, 0, (i == 3 || i == 7), (i == 5), 0);
        check_sel("run_cycles", 2'd0, 32'd10);
        check_sel("run_jumps", 2'd1, 32'd2);
        check_sel("run_branches", 2'd2, 32'd1);
        check_sel("run_halts", 2'd3, 32'd0);

        // Halt, freeze, then single step past the syscall
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("halt_state", 64'(state), 64'd2);
        check("halt_cpu_en", 64'(cpu_en), 64'd0);
        check_sel("halt_cnt", 2'd3, 32'd1);
        check_sel("halt_cycles", 2'd0, 32'd11);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        check_sel("frozen_cycles", 2'd0, 32'd11);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("step_state", 64'(state), 64'd3);
        check("step_cpu_en", 64'(cpu_en), 64'd1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("after_step_state", 64'(state), 64'd1);
        check_sel("step_cycles", 2'd0, 32'd12);
        check_sel("step_halts", 2'd3, 32'd1);
        idle(2);

        // Soft clear beats simultaneous events; then dual event
        cyc(0, 0, 0, 0, 1, 1, 1);
        check("cclr_state", 64'(state), 64'd1);
        read_all();
        cyc(0, 0, 0, 0, 1, 1, 0);
        check_sel("dual_cycles", 2'd0, 32'd1);
        check_sel("dual_jumps", 2'd1, 32'd1);
        check_sel("dual_branches", 2'd2, 32'd1);

        // 4-bit wrap from a fresh clear
        cyc(0, 0, 0, 0, 0, 0, 1);
        sel = 2'd0;
        for (int i = 1; i <= 17; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (i == 15) check("wrap15", 64'(cnt_out4), 64'd15);
            if (i == 16) check("wrap16", 64'(cnt_out4), 64'd0);
            if (i == 17) check("wrap17", 64'(cnt_out4), 64'd1);
        end
        check("wide17", 64'(cnt_out), 64'd17);

        // Reset from STEP and from HALT, then behave as from power-up
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0);
        check("pre_clr_step", 64'(state), 64'd3);
        cyc(1, 0, 1, 0, 0, 0, 0);
        check("clr_step_state", 64'(state), 64'd0);
        check("clr_step_cpu_en", 64'(cpu_en), 64'd0);
        read_all();
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("go_in_idle", 64'(state), 64'd0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("pre_clr_halt", 64'(state), 64'd2);
        cyc(1, 0, 0, 1, 0, 0, 0);
        check("clr_halt_state", 64'(state), 64'd0);
        read_all();
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_sel("restart_cycles", 2'd0, 32'd1);

        // Random mix, checked against the model every cycle
        for (int i = 0; i < 400; i++) begin
            sel = 2'($urandom_range(0, 3));
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0));
        end
        read_all();

        if (sb.size() != 0) check("sb_leftover", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
